// File: rtl/fma_round_pipe.sv
// Two-stage IEEE-style rounding back end: stage 1 slices the fraction and decides
// round-up, stage 2 applies the increment, carry-into-exponent and overflow.
module fma_round_pipe #(
  parameter int MW = 10,
  parameter int IW = 16,
  parameter int EW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [IW-1:0] in_mant,
  input  logic          in_sticky,
  input  logic [2:0]    in_rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-1:0] out_frac,
  output logic          out_nx,
  output logic          out_of,
  output logic          out_rmerr,
  output logic [15:0]   nx_count
);

  localparam int LW = IW - MW;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Stage 1 decode
  logic [MW-1:0] w_frac;
  logic          w_lsb, w_g, w_r, w_t, w_any;
  logic          w_exp_max;
  logic          w_rup, w_rmerr;
  logic          w_s1_rup, w_s1_nx;

  assign w_frac    = in_mant[IW-1:LW];
  assign w_lsb     = in_mant[LW];
  assign w_g       = in_mant[LW-1];
  assign w_r       = in_mant[LW-2];
  assign w_t       = (|in_mant[LW-3:0]) | in_sticky;
  assign w_any     = w_g | w_r | w_t;
  assign w_exp_max = &in_exp;

  always_comb begin
    w_rup   = 1'b0;
    w_rmerr = 1'b0;
    case (in_rm)
      RM_RNE:  w_rup = w_g & (w_r | w_t | w_lsb);
      RM_RTZ:  w_rup = 1'b0;
      RM_RDN:  w_rup = in_sign & w_any;
      RM_RUP:  w_rup = ~in_sign & w_any;
      RM_RMM:  w_rup = w_g;
      default: w_rmerr = 1'b1;
    endcase
  end

  // Inf/NaN encodings pass through untouched
  assign w_s1_rup = w_rup & ~w_exp_max;
  assign w_s1_nx  = w_any & ~w_exp_max;

  // Handshake
  logic r_s1_valid, r_s2_valid;
  logic w_s2_advance, w_in_fire;

  assign w_s2_advance = ~r_s2_valid | out_ready;
  assign in_ready     = ~r_s1_valid | w_s2_advance;
  assign w_in_fire    = in_valid & in_ready;

  logic          r_s1_sign, r_s1_rup, r_s1_nx, r_s1_rmerr;
  logic [EW-1:0] r_s1_exp;
  logic [MW-1:0] r_s1_frac;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
      r_s1_rup   <= 1'b0;
      r_s1_nx    <= 1'b0;
      r_s1_rmerr <= 1'b0;
    end else begin
      if (in_ready)
        r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_sign  <= in_sign;
        r_s1_exp   <= in_exp;
        r_s1_frac  <= w_frac;
        r_s1_rup   <= w_s1_rup;
        r_s1_nx    <= w_s1_nx;
        r_s1_rmerr <= w_rmerr;
      end
    end
  end

  // Stage 2 increment and exponent adjust
  logic [MW:0]   w_sum;
  logic          w_carry;
  logic [EW-1:0] w_exp_inc;
  logic [EW-1:0] w_s2_exp;
  logic [MW-1:0] w_s2_frac;
  logic          w_s2_of, w_s2_nx;

  assign w_sum     = {1'b0, r_s1_frac} + {{MW{1'b0}}, r_s1_rup};
  assign w_carry   = w_sum[MW];
  assign w_exp_inc = r_s1_exp + {{(EW-1){1'b0}}, 1'b1};
  assign w_s2_exp  = w_carry ? w_exp_inc : r_s1_exp;
  assign w_s2_frac = w_carry ? '0 : w_sum[MW-1:0];
  assign w_s2_of   = w_carry & (&w_exp_inc);
  assign w_s2_nx   = r_s1_nx | w_s2_of;

  logic          r_s2_sign, r_s2_nx, r_s2_of, r_s2_rmerr;
  logic [EW-1:0] r_s2_exp;
  logic [MW-1:0] r_s2_frac;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_frac  <= '0;
      r_s2_nx    <= 1'b0;
      r_s2_of    <= 1'b0;
      r_s2_rmerr <= 1'b0;
    end else if (w_s2_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign  <= r_s1_sign;
        r_s2_exp   <= w_s2_exp;
        r_s2_frac  <= w_s2_frac;
        r_s2_nx    <= w_s2_nx;
        r_s2_of    <= w_s2_of;
        r_s2_rmerr <= r_s1_rmerr;
      end
    end
  end

  // Counts inexact beats actually delivered downstream
  logic [15:0] r_nx_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_nx_count <= '0;
    else if (r_s2_valid & out_ready & r_s2_nx & (r_nx_count != 16'hFFFF))
      r_nx_count <= r_nx_count + 16'd1;
  end

  assign out_valid = r_s2_valid;
  assign out_sign  = r_s2_sign;
  assign out_exp   = r_s2_exp;
  assign out_frac  = r_s2_frac;
  assign out_nx    = r_s2_nx;
  assign out_of    = r_s2_of;
  assign out_rmerr = r_s2_rmerr;
  assign nx_count  = r_nx_count;

endmodule

// File: tb/tb_fma_round_pipe.sv
// Bench for fma_round_pipe: directed corner cases plus random traffic against a
// value-level rounding model and an in-order scoreboard.
module tb_fma_round_pipe;

  localparam int MW = 10;
  localparam int IW = 16;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [IW-1:0] in_mant;
  logic          in_sticky;
  logic [2:0]    in_rm;
  logic          out_valid, out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_frac;
  logic          out_nx, out_of, out_rmerr;
  logic [15:0]   nx_count;

  fma_round_pipe #(.MW(MW), .IW(IW), .EW(EW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_sticky(in_sticky), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_nx(out_nx), .out_of(out_of), .out_rmerr(out_rmerr),
    .nx_count(nx_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [18:0] sb[$];
  logic [15:0] exp_cnt;
  logic        have_hold;
  logic [18:0] hold_val;
  logic [18:0] packed_out;

  assign packed_out = {out_sign, out_exp, out_frac, out_nx, out_of, out_rmerr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [18:0] pk(input logic s, input logic [4:0] e, input logic [9:0] f,
                                     input logic nx, input logic of, input logic re);
    return {s, e, f, nx, of, re};
  endfunction

  // Value-level model: the discarded tail is compared against one half ULP.
  function automatic logic [18:0] model(input logic s, input logic [4:0] e, input logic [15:0] m,
                                        input logic st, input logic [2:0] rm);
    int unsigned ulp, half, low, frac, v;
    logic inexact, up, of, rmerr;
    logic [2:0] r;
    logic [4:0] eo;
    logic [9:0] fo;
    ulp   = 2 ** (IW - MW);
    half  = ulp / 2;
    low   = m % ulp;
    frac  = m / ulp;
    inexact = (low != 0) || st;
    rmerr = (rm > 3'd4);
    r     = rmerr ? 3'd1 : rm;
    case (r)
      3'd0:    up = (low > half) || (low == half && (st || (frac % 2 == 1)));
      3'd2:    up = s && inexact;
      3'd3:    up = !s && inexact;
      3'd4:    up = (low >= half);
      default: up = 1'b0;
    endcase
    if (e == 5'h1F) begin
      fo = frac[9:0];
      return pk(s, e, fo, 1'b0, 1'b0, rmerr);
    end
    v  = frac + (up ? 1 : 0);
    eo = e;
    of = 1'b0;
    if (v == 2 ** MW) begin
      v  = 0;
      eo = e + 5'd1;
      of = (eo == 5'h1F);
    end
    fo = v[9:0];
    return pk(s, eo, fo, inexact || of, of, rmerr);
  endfunction

  // Monitor: scoreboard, stall stability and delivered-inexact counter
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_cnt   = 16'd0;
      have_hold = 1'b0;
    end else begin
      check("nx_count", {16'd0, nx_count}, {16'd0, exp_cnt});
      if (have_hold && out_valid)
        check("stall_hold", {13'd0, packed_out}, {13'd0, hold_val});
      have_hold = out_valid && !out_ready;
      hold_val  = packed_out;
      if (in_valid && in_ready)
        sb.push_back(model(in_sign, in_exp, in_mant, in_sticky, in_rm));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_beat", 32'd1, 32'd0);
        end else begin
          logic [18:0] e;
          e = sb.pop_front();
          check("beat", {13'd0, packed_out}, {13'd0, e});
          if (e[2] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic s, input logic [4:0] e, input logic [15:0] m,
                      input logic st, input logic [2:0] rm);
    int waited;
    in_sign = s; in_exp = e; in_mant = m; in_sticky = st; in_rm = rm;
    in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic s, input logic [4:0] e,
                          input logic [15:0] m, input logic st, input logic [2:0] rm,
                          input logic [18:0] expv);
    bit seen;
    out_ready = 1'b1;
    send(s, e, m, st, rm);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    check(tag, {13'd0, packed_out}, {13'd0, expv});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drained", sb.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0; in_rm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_outputs", {13'd0, packed_out}, 32'd0);
    check("reset_nx_count", {16'd0, nx_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge E0, visible after E1
    send(1'b0, 5'h0F, 16'h1234, 1'b0, 3'd0);
    @(negedge clk);
    check("latency_s1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_s2", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    directed("rne_tie_up",   1'b0, 5'h0F, 16'h0060, 1'b0, 3'b000, pk(1'b0, 5'h0F, 10'h002, 1'b1, 1'b0, 1'b0));
    directed("rne_tie_down", 1'b0, 5'h0F, 16'h0020, 1'b0, 3'b000, pk(1'b0, 5'h0F, 10'h000, 1'b1, 1'b0, 1'b0));
    directed("carry",        1'b0, 5'h0E, 16'hFFE0, 1'b0, 3'b011, pk(1'b0, 5'h0F, 10'h000, 1'b1, 1'b0, 1'b0));
    directed("carry_of",     1'b0, 5'h1E, 16'hFFE0, 1'b0, 3'b011, pk(1'b0, 5'h1F, 10'h000, 1'b1, 1'b1, 1'b0));
    directed("rdn_neg",      1'b1, 5'h0F, 16'h0041, 1'b0, 3'b010, pk(1'b1, 5'h0F, 10'h002, 1'b1, 1'b0, 1'b0));
    directed("rdn_pos",      1'b0, 5'h0F, 16'h0041, 1'b0, 3'b010, pk(1'b0, 5'h0F, 10'h001, 1'b1, 1'b0, 1'b0));
    directed("rdn_inf",      1'b1, 5'h1F, 16'h0041, 1'b0, 3'b010, pk(1'b1, 5'h1F, 10'h001, 1'b0, 1'b0, 1'b0));
    directed("rm_reserved",  1'b0, 5'h0E, 16'hFFE0, 1'b0, 3'b101, pk(1'b0, 5'h0E, 10'h3FF, 1'b1, 1'b0, 1'b1));
    directed("sticky_rmm",   1'b0, 5'h03, 16'h0010, 1'b1, 3'b100, pk(1'b0, 5'h03, 10'h000, 1'b1, 1'b0, 1'b0));

    // Back-pressure: four beats, out_ready low for three cycles
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(i[0], 5'h05 + 5'(i), 16'($urandom), 1'($urandom), 3'($urandom_range(0, 4)));
      end
      begin
        out_ready = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), 3'($urandom));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(1'b0, 5'h0A, 16'h0041, 1'b0, 3'd3);
    send(1'b1, 5'h0B, 16'h0021, 1'b0, 3'd2);
    #2 reset = 1'b1;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_nx_count", {16'd0, nx_count}, 32'd0);
    check("midreset_outputs", {13'd0, packed_out}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("no_ghost_beat", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Counter saturation: 65537 inexact finite beats
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++)
      send(1'($urandom), 5'($urandom_range(0, 30)), 16'($urandom) | 16'h0001, 1'b0, 3'($urandom));
    drain();
    check("nx_saturated", {16'd0, nx_count}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
